pipe_stage_skid_reg: RTL and testbench

- Parametrised successor to the decode→execute pipeline register; usable between any two pipeline stages.
- Carries PC, instruction and a configurable operand payload (e.g. rs data, rt data, EXT data = 96 bits).
- Uses a valid/ready handshake with a 2-entry skid buffer, so a stall holds data instead of destroying it, and a separate flush inserts a bubble.
- Provides occupancy and a saturating stall-cycle counter for hazard debug.

---
 rtl/pipe_pkg.sv | 12 +
 rtl/pipe_entry_reg.sv | 42 ++++
 rtl/pipe_stage_skid_reg.sv | 109 ++++++++++
 tb/tb_pipe_stage_skid_reg.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the skid-buffered pipeline register.
package pipe_pkg;

  localparam int unsigned PC_W = 32;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  // Packed entry: {pc, instr, payload}
  function automatic int unsigned entry_w(input int unsigned payload_w);
    return 64 + payload_w;
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: a valid bit plus a packed data word.
module pipe_entry_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic         valid_o,
  output logic [W-1:0] q_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Clear drops only the valid bit so stale data stays observable.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = d_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign q_o     = data_q;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Valid/ready pipeline register with a 2-entry skid buffer,
// flush-to-bubble, output masking and a saturating stall counter.
module pipe_stage_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned PAYLOAD_W       = 96,
  parameter int unsigned CNT_W           = 16,
  parameter logic [31:0] NOP_INSTR       = NOP_INSTR_DEFAULT,
  parameter bit          CLEAR_ON_BUBBLE = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PC_W-1:0]      in_pc,
  input  logic [31:0]          in_instr,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PC_W-1:0]      out_pc,
  output logic [31:0]          out_instr,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_cycles
);

  localparam int unsigned E_W = entry_w(PAYLOAD_W);

  logic           main_v, skid_v;
  logic [E_W-1:0] main_q, skid_q;
  logic [E_W-1:0] in_e, main_d;
  logic           acc, pop;
  logic           main_ld, main_clr;
  logic           skid_ld, skid_clr;
  logic [CNT_W-1:0] stall_q, stall_d;

  assign in_e     = {in_pc, in_instr, in_payload};
  assign in_ready = !skid_v;
  assign acc      = in_valid & in_ready;
  assign pop      = main_v & out_ready;

  // A full skid always drains into main before new input is taken.
  assign main_d  = skid_v ? skid_q : in_e;
  assign main_ld = !flush &
                   ((skid_v & pop) |
                    (!skid_v & acc & (!main_v | pop)));
  assign main_clr = flush | (pop & !main_ld);
  assign skid_ld  = !flush & !skid_v & acc & main_v & !pop;
  assign skid_clr = flush | (skid_v & pop);

  pipe_entry_reg #(.W(E_W)) u_main (
    .clk_i  (clk),
    .rst_ni (reset),
    .load_i (main_ld),
    .clr_i  (main_clr),
    .d_i    (main_d),
    .valid_o(main_v),
    .q_o    (main_q)
  );

  pipe_entry_reg #(.W(E_W)) u_skid (
    .clk_i  (clk),
    .rst_ni (reset),
    .load_i (skid_ld),
    .clr_i  (skid_clr),
    .d_i    (in_e),
    .valid_o(skid_v),
    .q_o    (skid_q)
  );

  logic [PC_W-1:0]      m_pc;
  logic [31:0]          m_instr;
  logic [PAYLOAD_W-1:0] m_pay;

  assign {m_pc, m_instr, m_pay} = main_q;

  assign out_valid   = main_v;
  assign out_instr   = main_v ? m_instr : NOP_INSTR;
  assign out_pc      = (main_v || !CLEAR_ON_BUBBLE) ? m_pc : '0;
  assign out_payload = (main_v || !CLEAR_ON_BUBBLE) ? m_pay : '0;
  assign occupancy   = {1'b0, main_v} + {1'b0, skid_v};

  always_comb begin
    stall_d = stall_q;
    if (main_v && !out_ready && !(&stall_q))
      stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;

  a_skid_main : assert property (@(posedge clk)
    disable iff (!reset) skid_v |-> main_v);

  a_occ : assert property (@(posedge clk)
    disable iff (!reset) occupancy != 2'd3);

  a_hold : assert property (@(posedge clk)
    disable iff (!reset)
    (in_valid && !in_ready && !flush) |=>
      (in_valid && $stable(in_pc) &&
       $stable(in_instr) && $stable(in_payload)));

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed bench: two instances share stimulus; the second uses
// CNT_W=4, CLEAR_ON_BUBBLE=0 and a non-zero NOP word.
module tb_pipe_stage_skid_reg;

  localparam int unsigned PW = 96;
  localparam logic [31:0] NOP_B = 32'hDEAD_0013;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [31:0]   in_pc = '0;
  logic [31:0]   in_instr = '0;
  logic [PW-1:0] in_payload = '0;

  logic          a_in_ready, a_out_valid;
  logic [31:0]   a_out_pc, a_out_instr;
  logic [PW-1:0] a_out_payload;
  logic [1:0]    a_occ;
  logic [15:0]   a_stall;

  logic          b_in_ready, b_out_valid;
  logic [31:0]   b_out_pc, b_out_instr;
  logic [PW-1:0] b_out_payload;
  logic [1:0]    b_occ;
  logic [3:0]    b_stall;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pipe_stage_skid_reg dut_a (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_payload(in_payload),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_out_pc), .out_instr(a_out_instr),
    .out_payload(a_out_payload), .occupancy(a_occ),
    .stall_cycles(a_stall)
  );

  pipe_stage_skid_reg #(
    .PAYLOAD_W(PW), .CNT_W(4),
    .NOP_INSTR(NOP_B), .CLEAR_ON_BUBBLE(1'b0)
  ) dut_b (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_payload(in_payload),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_out_pc), .out_instr(b_out_instr),
    .out_payload(b_out_payload), .occupancy(b_occ),
    .stall_cycles(b_stall)
  );

  function automatic logic [PW-1:0] pay(input logic [31:0] pc);
    return {pc, ~pc, pc + 32'd1};
  endfunction

  function automatic logic [31:0] ins(input logic [31:0] pc);
    return pc ^ 32'h0000_0013;
  endfunction

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] pc);
    in_valid   = v;
    in_pc      = pc;
    in_instr   = ins(pc);
    in_payload = pay(pc);
  endtask

  initial begin
    // 1: reset
    tick();
    tick();
    reset = 1'b1;
    check("rst_valid", a_out_valid, 0);
    check("rst_instr", a_out_instr, 0);
    check("rst_occ", a_occ, 0);
    check("rst_stall", a_stall, 0);
    check("rst_ready", a_in_ready, 1);
    check("rst_nop_b", b_out_instr, NOP_B);

    // 2: streaming
    out_ready = 1'b1;
    drive(1, 32'h3000);
    tick();
    check("s0_valid", a_out_valid, 1);
    check("s0_pc", a_out_pc, 32'h3000);
    check("s0_instr", a_out_instr, ins(32'h3000));
    check("s0_pay", a_out_payload, pay(32'h3000));
    check("s0_occ", a_occ, 1);
    drive(1, 32'h3004);
    tick();
    check("s1_pc", a_out_pc, 32'h3004);
    check("s1_occ", a_occ, 1);
    drive(1, 32'h3008);
    tick();
    check("s2_pc", a_out_pc, 32'h3008);
    check("s2_occ", a_occ, 1);
    drive(0, 32'h0);
    tick();
    check("s3_valid", a_out_valid, 0);
    check("s3_pc_clr", a_out_pc, 0);
    check("s3_pay_clr", a_out_payload, 0);
    check("s3_stall", a_stall, 0);

    // 3: stall with skid
    out_ready = 1'b0;
    drive(1, 32'h3000);
    tick();
    drive(1, 32'h3004);
    tick();
    check("k_occ2", a_occ, 2);
    check("k_ready0", a_in_ready, 0);
    check("k_pc", a_out_pc, 32'h3000);
    drive(0, 32'h0);
    tick();
    tick();
    check("k_pc_hold", a_out_pc, 32'h3000);
    check("k_stall", a_stall, 3);
    out_ready = 1'b1;
    tick();
    check("k_d0_pc", a_out_pc, 32'h3004);
    check("k_d0_occ", a_occ, 1);
    check("k_d0_ready", a_in_ready, 1);
    tick();
    check("k_d1_valid", a_out_valid, 0);
    check("k_stall_end", a_stall, 3);

    // 4: flush with concurrent input
    out_ready = 1'b0;
    drive(1, 32'h3000);
    tick();
    drive(1, 32'h3004);
    tick();
    check("f_occ2", a_occ, 2);
    drive(1, 32'h3008);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(0, 32'h0);
    check("f_valid", a_out_valid, 0);
    check("f_occ", a_occ, 0);
    check("f_instr", a_out_instr, 0);
    check("f_pc", a_out_pc, 0);
    check("f_ready", a_in_ready, 1);
    check("f_stall", a_stall, 5);
    tick();
    check("f_no3008", a_out_valid, 0);

    // 5: reset mid-operation
    drive(1, 32'h3000);
    tick();
    drive(1, 32'h3004);
    tick();
    drive(0, 32'h0);
    check("r_occ2", a_occ, 2);
    check("r_stall6", a_stall, 6);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("r_valid", a_out_valid, 0);
    check("r_occ", a_occ, 0);
    check("r_stall", a_stall, 0);
    check("r_ready", a_in_ready, 1);
    check("r_pc", a_out_pc, 0);
    check("r_pay", a_out_payload, 0);
    check("r_b_pc", b_out_pc, 0);

    // 6: stale outputs and saturation
    out_ready = 1'b1;
    drive(1, 32'h3010);
    tick();
    check("b_pc", b_out_pc, 32'h3010);
    drive(0, 32'h0);
    tick();
    check("b_bub_valid", b_out_valid, 0);
    check("b_stale_pc", b_out_pc, 32'h3010);
    check("b_stale_pay", b_out_payload, pay(32'h3010));
    check("b_nop", b_out_instr, NOP_B);
    check("a_clr_pc", a_out_pc, 0);
    out_ready = 1'b0;
    drive(1, 32'h3014);
    tick();
    drive(0, 32'h0);
    for (int i = 0; i < 20; i++) tick();
    check("b_sat", b_stall, 4'hF);
    check("a_cnt20", a_stall, 20);
    check("b_pc_hold", b_out_pc, 32'h3014);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
